adder_share_ctrl: RTL
=====================

# adder_share_ctrl

Controller that time-shares one `adder` datapath among `N_REQ` requesters. It arbitrates round-robin, latches the winner's operands and registers the adder output. It returns the sum, carry and requester ID over a valid/ready response channel. It sits between the requesting client blocks and the single adder instance, which it owns and sequences.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: operand and sum width in bits.
- `ID_W`, default `$clog2(N_REQ)`: response ID width (derived; do not override).

- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  `N_REQ`: per-requester request level; held until granted.
- `a_in`  in  `N_REQ*WIDTH`: operand A, requester i at bits `[i*WIDTH +: WIDTH]`.
- `b_in`  in  `N_REQ*WIDTH`: operand B, same packing as `a_in`.
- `gnt`  out  `N_REQ`: one-hot grant, combinational, high only in `IDLE`.
- `busy`  out  1: high in `CALC` and `RESP`.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts result.
- `rsp_id`  out  `ID_W`: index of the granted requester.
- `rsp_sum`  out  `WIDTH`: `(a+b) mod 2^WIDTH`.
- `rsp_carry`  out  1: bit `WIDTH` of `a+b`.

## Operation
- The FSM has three states: `IDLE`, `CALC` and `RESP`.
- `IDLE`:
  - If `req != 0`, the round-robin arbiter picks the winner: the first set bit at or above `rr_ptr`, wrapping.
  - `gnt[winner]` is asserted combinationally.
  - At the clock edge, the winner's `a_in`/`b_in` are latched into `op_a`/`op_b`, `rsp_id` is set to the winner, `rr_ptr` becomes `(winner+1) mod N_REQ`, and the FSM goes to `CALC`.
  - If `req == 0`, the FSM stays in `IDLE`, `gnt = 0`, and `rr_ptr` is unchanged.
- `CALC`:
  - The adder is driven with `op_a`/`op_b`, extended to `WIDTH+1` bits.
  - At the edge, the adder output is registered into `{rsp_carry, rsp_sum}` and the FSM goes to `RESP`.
- `RESP`:
  - `rsp_valid = 1`.
  - On an edge with `rsp_ready = 1`, the FSM returns to `IDLE`; otherwise it holds.
  - `rsp_sum`, `rsp_carry` and `rsp_id` are stable while `rsp_valid` is high and not ready.
- Requester rules:
  - A requester treats an edge with `gnt[i] = 1` as operand acceptance.
  - After that edge it may drop `req[i]` or present a new operation.
  - Operand changes while `req[i]` is high and `gnt[i]` is low are allowed; the values latched are those present at the grant edge.
- `req` bits are ignored outside `IDLE`; there is no queuing and no grant is remembered.
- Arithmetic: the sum is unsigned. Example: `WIDTH=8`, `0xFF + 0x01` gives sum `0x00`, carry 1.
- Reset (`rst_n = 0` at any edge, including mid-`CALC` or mid-`RESP`):
  - State goes to `IDLE`, `rr_ptr = 0`, `op_a = op_b = 0`.
  - `rsp_sum = 0`, `rsp_carry = 0`, `rsp_id = 0`, `rsp_valid = 0`.
  - `gnt` is forced to 0 while `rst_n = 0`.
  - An in-flight operation is discarded with no response.
- Output values after reset: `gnt = 0`, `busy = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_carry = 0`.

## Timing
- Grant is same-cycle: `req` high in `IDLE` gives `gnt` high in that cycle.
- Edge-by-edge sequence for one operation:
  - Grant edge E0: state goes to `CALC`.
  - E1: result registered, `rsp_valid` rises after E1.
  - `rsp_ready` held high: the handshake completes at E2, and the FSM is back in `IDLE` after E2.
  - The next grant can occur in the `IDLE` cycle following E2, so the next grant edge is E3.
- Minimum issue interval: 3 cycles per operation.
- Result latency: 2 cycles from the grant edge to `rsp_valid`.
- Back-pressure: each cycle `rsp_ready` is low in `RESP` adds one cycle; `busy` stays high throughout.
- Fairness: with all requesters continuously requesting, each is granted exactly once every `N_REQ` operations.

## Structure
- Shared package `adder_pkg`:
  - State enum `adder_ctrl_state_t` with values `IDLE`, `CALC` and `RESP`.
  - Reset-value constants.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, binary `idx`, `any`.
  - Purely combinational; the pointer register stays in `adder_share_ctrl`.
- The adder is instantiated once inside `adder_share_ctrl` at `WIDTH+1` bits.

## Test plan
- Reset mid-operation: grant req0, assert `rst_n = 0` in `CALC` → all outputs 0 next cycle; `rsp_valid` never rises; the next op with req2 only grants `gnt[2]`.
- Single op: `req = 4'b0010`, `a1 = 0x12`, `b1 = 0x34`, `rsp_ready = 1` → `gnt = 0010` for one cycle; 2 cycles later `rsp_valid = 1`, `rsp_id = 1`, `sum = 0x46`, `carry = 0`.
- Carry/wrap: `a0 = 0xFF`, `b0 = 0x01` → `sum = 0x00`, `carry = 1`; `a0 = 0x80`, `b0 = 0x80` → `sum = 0x00`, `carry = 1`.
- Round-robin: `req = 1111` held with `rsp_ready = 1` → grant order 0,1,2,3,0; issue interval exactly 3 cycles.
- Back-pressure: `rsp_ready = 0` for 5 cycles in `RESP` → `rsp_valid`, `rsp_sum` and `rsp_id` stable; `gnt = 0` with `req = 1111`; the grant resumes in the first cycle after the accepting edge.
- Pointer wrap and skip: `rr_ptr = 3`, `req = 0101` → grants 0 then 2 then 0; req3 raised later is granted before req0 when `rr_ptr = 3`.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and reset values for the time-shared adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

  // Controller sequencing: arbitrate, add, hold response until accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } adder_ctrl_state_t;

  // Reset values. Operand, sum, id and pointer registers reset to all-zero.
  localparam adder_ctrl_state_t RST_STATE = IDLE;
  localparam logic              RST_CARRY = 1'b0;

endpackage

// File: rtl/adder.sv
// Plain unsigned adder used as the shared datapath; caller supplies the carry headroom.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b operands (W bits); o_sum = (i_a + i_b) mod 2^W.
module adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin picker: first set request at or above ptr, wrapping to bit 0.
// Latency: combinational.
// Backpressure: none; the pointer register lives in the caller.
// Ports: req/ptr in; one-hot gnt, binary idx of the winner, any = at least one request.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     w_rot;
  logic [PTR_W-1:0] w_off;
  logic [PTR_W:0]   w_sum;

  // Rotate so the pointer position lands at bit 0; the first set bit of the
  // rotated vector is then the distance from ptr to the winner.
  assign w_rot = N'({req, req} >> ptr);

  always_comb begin
    any   = 1'b0;
    w_off = '0;
    for (int j = 0; j < N; j++) begin
      if (!any && w_rot[j]) begin
        any   = 1'b1;
        w_off = PTR_W'(j);
      end
    end
  end

  // Undo the rotation: winner = (ptr + offset) mod N.
  assign w_sum = {1'b0, ptr} + {1'b0, w_off};
  assign idx   = (w_sum >= (PTR_W+1)'(N)) ? PTR_W'(w_sum - (PTR_W+1)'(N)) : w_sum[PTR_W-1:0];
  assign gnt   = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one adder among N_REQ requesters: round-robin grant, registered sum/carry/id response.
// Latency: grant same cycle as request in IDLE; rsp_valid 2 cycles after the grant edge; 3-cycle minimum issue interval.
// Backpressure: response held stable while rsp_ready is low; no grants until the response is accepted.
// Ports: clk, rst_n (sync, active-low); req/a_in/b_in from requesters; gnt one-hot grant;
//        busy; rsp_valid/rsp_ready handshake carrying rsp_id, rsp_sum, rsp_carry.
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry
);

  adder_ctrl_state_t r_state;
  adder_ctrl_state_t w_state_nxt;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [ID_W-1:0]  r_id;

  logic [N_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]  w_arb_idx;
  logic             w_arb_any;
  logic             w_take;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH:0]   w_add;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (ID_W)
  ) u_arb (
    .req (req),
    .ptr (r_rr_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .any (w_arb_any)
  );

  // Single shared adder, one bit wider so the carry falls out as the MSB.
  adder #(
    .W (WIDTH + 1)
  ) u_adder (
    .i_a   ({1'b0, r_op_a}),
    .i_b   ({1'b0, r_op_b}),
    .o_sum (w_add)
  );

  // Requests only count in IDLE; reset also masks the grant so no requester
  // mistakes a reset edge for operand acceptance.
  assign w_take    = (r_state == IDLE) && w_arb_any;
  assign gnt       = (rst_n && r_state == IDLE) ? w_arb_gnt : '0;
  assign w_ptr_nxt = (w_arb_idx == ID_W'(N_REQ - 1)) ? '0 : w_arb_idx + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_state_nxt = CALC;
      CALC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RST_STATE;
      r_rr_ptr <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum    <= '0;
      r_carry  <= RST_CARRY;
      r_id     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_op_a   <= a_in[w_arb_idx*WIDTH +: WIDTH];
        r_op_b   <= b_in[w_arb_idx*WIDTH +: WIDTH];
        r_id     <= w_arb_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (r_state == CALC) begin
        {r_carry, r_sum} <= w_add;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;

endmodule
